cdc_handshake_arbiter: RTL and testbench

Source-domain controller that shares one four-phase req/ack clock-domain crossing among N_REQ local requesters. It round-robin arbitrates requesters and holds the winner's ID and data stable on the crossing bus. It drives the req line into the far-domain synchronizer and sequences the handshake from the returning ack, which arrives already synchronized into this clock. It reports completion or timeout per transfer.

---
 rtl/cdc_handshake_arbiter.sv | 155 +++++++++++++++
 tb/tb_cdc_handshake_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_arbiter.sv
// rtl/cdc_handshake_arbiter.sv - round-robin arbiter sharing one four-phase req/ack crossing
// Source-domain side of a shared req/ack crossing: picks a requester, holds its
// id/payload on the crossing bus, sequences the four-phase handshake from the
// synchronized ack and reports completion or a per-phase timeout.
module cdc_handshake_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  parameter int ID_WIDTH   = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          xfer_req,
  output logic [ID_WIDTH-1:0]           xfer_id,
  output logic [DATA_WIDTH-1:0]         xfer_data,
  input  logic                          xfer_ack_sync,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout_err,
  output logic [ID_WIDTH-1:0]           evt_id
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
  localparam int IDX_W = ID_WIDTH + 1;
  localparam logic [IDX_W-1:0] N_EXT = IDX_W'(N_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  grant_id;
  logic [ID_WIDTH-1:0]  ptr_nxt;
  logic                 grant_found;
  logic [IDX_W-1:0]     cand;
  logic                 accept;
  logic                 aborted;
  logic [CNT_W-1:0]     phase_cnt;
  logic                 tmo_hit;
  logic                 done_set;
  logic                 tmo_set;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + IDX_W'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_WIDTH-1:0];
      end
    end
  end

  // A stale ack in IDLE blocks acceptance; reset also masks the ready strobe.
  assign accept  = rst_n && (state == S_IDLE) && !xfer_ack_sync && grant_found;
  assign ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign tmo_hit = (TIMEOUT != 0) && (phase_cnt == TMO_VAL);

  // One-hot acceptance strobe toward the winning requester.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: ack level drives the handshake, timeout forces progress.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_REQ;
      S_REQ:     if (xfer_ack_sync || tmo_hit) state_nxt = S_RELEASE;
      S_RELEASE: if (!xfer_ack_sync || tmo_hit) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode: busy level plus the completion/timeout events for next cycle.
  always_comb begin
    busy     = (state != S_IDLE);
    done_set = (state == S_RELEASE) && !xfer_ack_sync && !aborted;
    tmo_set  = tmo_hit && (((state == S_REQ) && !xfer_ack_sync) ||
                           ((state == S_RELEASE) && xfer_ack_sync));
  end

  // Crossing bus: req follows the next state so it leaves a flop glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_req  <= 1'b0;
      xfer_id   <= '0;
      xfer_data <= '0;
      rr_ptr    <= '0;
    end else begin
      xfer_req <= (state_nxt == S_REQ);
      if (accept) begin
        xfer_id   <= grant_id;
        xfer_data <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr    <= ptr_nxt;
      end
    end
  end

  // Phase counter: cleared on every state change, saturates at the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (state_nxt != state) begin
      phase_cnt <= '0;
    end else if (phase_cnt != TMO_VAL) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Aborted flag: a REQ timeout suppresses the later done; cleared leaving RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted <= 1'b0;
    end else if ((state == S_REQ) && tmo_set) begin
      aborted <= 1'b1;
    end else if ((state == S_RELEASE) && (state_nxt != S_RELEASE)) begin
      aborted <= 1'b0;
    end
  end

  // Event pulses with the id of the transfer they qualify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      evt_id      <= '0;
    end else begin
      done        <= done_set;
      timeout_err <= tmo_set;
      if (done_set || tmo_set) evt_id <= xfer_id;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// tb/tb_cdc_handshake_arbiter.sv - scoreboard bench for cdc_handshake_arbiter
module tb_cdc_handshake_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          xfer_req;
  logic [1:0]    xfer_id;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack_sync = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [1:0]    evt_id;

  cdc_handshake_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .xfer_req(xfer_req), .xfer_id(xfer_id),
    .xfer_data(xfer_data), .xfer_ack_sync(xfer_ack_sync), .busy(busy),
    .done(done), .timeout_err(timeout_err), .evt_id(evt_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          kind;
  } sb_t;

  sb_t  sb[$];
  sb_t  cur;
  bit   cur_valid = 0;
  int   grants[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_ptr = 0;
  logic exp_kind = 1'b0;
  int   ack_mode = 0;
  logic ack_force = 1'b0;
  int   echo_d = 3;
  logic [7:0] req_hist = '0;
  logic [N-1:0] nxt_valid = '0;
  int   n_done = 0, n_tmo = 0, n_ready_cycles = 0, n_req_hi = 0, acc_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive inputs after the edge, observe and score at the falling edge.
  task automatic tick();
    sb_t e;
    int  w;
    @(posedge clk);
    #1;
    req_hist = {req_hist[6:0], xfer_req};
    xfer_ack_sync = (ack_mode == 0) ? req_hist[echo_d] : ack_force;
    req_valid = nxt_valid;
    @(negedge clk);
    if (xfer_req) n_req_hi++;
    if (done || timeout_err) begin
      check("done_tmo_excl", {31'd0, done & timeout_err}, 0);
      check("evt_pending", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("evt_id", evt_id, e.id);
        check("evt_kind", {31'd0, timeout_err}, {31'd0, e.kind});
      end
      n_done += done;
      n_tmo  += timeout_err;
    end
    if (busy && cur_valid) begin
      check("xfer_id_hold", xfer_id, cur.id);
      check("xfer_data_hold", xfer_data, cur.data);
    end
    if (req_ready != 0) begin
      n_ready_cycles++;
      w = rr_pick(exp_ptr, req_valid);
      check("ready_onehot", req_ready, (w < 0) ? 0 : (1 << w));
      check("accept_ack_low", xfer_ack_sync, 0);
      if (w >= 0) begin
        e.id = 2'(w);
        e.data = req_data[w*DW +: DW];
        e.kind = exp_kind;
        sb.push_back(e);
        cur = e;
        cur_valid = 1;
        exp_ptr = (w + 1) % N;
        grants.push_back(w);
        acc_count++;
      end
    end
  endtask

  task automatic wait_accept(input int budget);
    int start = acc_count;
    for (int i = 0; i < budget && acc_count == start; i++) tick();
    check("accept_seen", {31'd0, acc_count != start}, 1);
  endtask

  task automatic wait_evt(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done || timeout_err) seen = 1;
    end
    check("evt_seen", {31'd0, seen}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim_time got=expired exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, t0, target;
    bit found;
    int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = 8'($urandom);
    req_data[2*DW +: DW] = 8'hA5;

    // reset state, with every requester asking
    nxt_valid = 4'b1111;
    tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_xfer_req", xfer_req, 0);
    check("rst_busy", busy, 0);
    check("rst_xfer_id", xfer_id, 0);
    check("rst_xfer_data", xfer_data, 0);
    check("rst_done", done, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_evt_id", evt_id, 0);
    nxt_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // single transfer, requester 2, ack echoes with 3-cycle delay
    ack_mode = 0; exp_kind = 0;
    d0 = n_done; r0 = n_ready_cycles;
    nxt_valid = 4'b0100;
    wait_accept(10);
    nxt_valid = '0;
    check("single_grant", grants[$], 2);
    wait_evt(30);
    repeat (5) tick();
    check("single_done_cnt", n_done - d0, 1);
    check("single_ready_cycles", n_ready_cycles - r0, 1);

    // pointer left at 3 by the previous grant
    nxt_valid = 4'b1111;
    wait_accept(10);
    nxt_valid = '0;
    check("ptr_after_single", grants[$], 3);
    wait_evt(30);

    // round robin: eight back-to-back transfers with all requesters valid
    target = acc_count + 8;
    r0 = grants.size();
    nxt_valid = 4'b1111;
    for (int i = 0; i < 200 && acc_count < target; i++) tick();
    nxt_valid = '0;
    check("rr_count", acc_count, target);
    wait_evt(30);
    for (int k = 0; k < 8 && r0 + k < grants.size(); k++) begin
      check("rr_order", grants[r0 + k], rr_exp[k]);
      if (k > 0) check("rr_no_repeat", {31'd0, grants[r0 + k] == grants[r0 + k - 1]}, 0);
    end
    check("rr_sb_empty", sb.size(), 0);

    // REQ timeout with ack held low
    ack_mode = 1; ack_force = 0; exp_kind = 1;
    d0 = n_done; t0 = n_tmo;
    nxt_valid = 4'b0010;
    wait_accept(10);
    nxt_valid = '0;
    n_req_hi = 0;
    wait_evt(30);
    check("tmo_req_high_cycles", n_req_hi, TO + 1);
    check("tmo_pulse", n_tmo - t0, 1);
    tick();
    check("tmo_idle_next", busy, 0);
    check("tmo_no_done", n_done - d0, 0);

    // late ack after an aborted transfer
    nxt_valid = 4'b0100;
    wait_accept(10);
    nxt_valid = '0;
    wait_evt(30);
    tick();
    check("late_idle", busy, 0);
    ack_force = 1;
    nxt_valid = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("late_ready_blocked", req_ready, 0);
    end
    check("late_no_done", n_done - d0, 0);
    ack_mode = 0; exp_kind = 0;
    tick();
    check("late_accept_on_ack_low", req_ready, 4'b1000);
    nxt_valid = '0;
    wait_evt(30);
    check("late_done_cnt", n_done - d0, 1);

    // stuck ack in IDLE blocks requester 0
    ack_mode = 1; ack_force = 1;
    nxt_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stuck_ready_blocked", req_ready, 0);
    end
    ack_mode = 0;
    tick();
    check("stuck_accept", req_ready, 4'b0001);
    nxt_valid = '0;
    wait_evt(30);

    // reset while in RELEASE
    nxt_valid = 4'b0100;
    wait_accept(10);
    nxt_valid = '0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (busy && !xfer_req) found = 1;
    end
    check("release_reached", {31'd0, found}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_xfer_req", xfer_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_xfer_id", xfer_id, 0);
    check("mid_rst_xfer_data", xfer_data, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_tmo", timeout_err, 0);
    check("mid_rst_evt_id", evt_id, 0);
    check("mid_rst_req_ready", req_ready, 0);
    sb.delete();
    cur_valid = 0;
    exp_ptr = 0;
    d0 = n_done; t0 = n_tmo;
    repeat (4) tick();
    check("mid_rst_no_evt", (n_done - d0) + (n_tmo - t0), 0);
    rst_n = 1'b1;
    nxt_valid = 4'b0110;
    wait_accept(10);
    nxt_valid = '0;
    check("post_rst_grant", grants[$], 1);
    wait_evt(30);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
